// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, sync polarity levels and raster region decode
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_CLK_DIV = 2;
  localparam bit SYNC_ACTIVE_LOW = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_e;
  function automatic region_e region(int pos, int act, int fp, int sync);
    return pos < act ? ACTIVE : pos < act + fp ? FRONT : pos < act + fp + sync ? SYNC : BACK;
  endfunction
endpackage

// File: rtl/vga_pixel_strobe.sv
// vga_pixel_strobe: CLK_DIV divider giving a combinational pixel step and a registered pixel_en strobe
module vga_pixel_strobe #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic restart,
  output logic step,
  output logic pixel_en
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic pixel_en_q, last;
  always_comb begin
    last = div_q == DW'(CLK_DIV - 1);
    step = enable && !restart && last;
    div_d = restart || (enable && last) ? '0 : enable ? div_q + 1'b1 : div_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      div_q <= '0;
      pixel_en_q <= 1'b0;
    end else begin
      div_q <= div_d;
      pixel_en_q <= step;
    end
  assign pixel_en = pixel_en_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator; defining VGA_TIMING_FRAME_CNT_EN adds the frame_count port
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int COL_W = $clog2(H_TOTAL),
  localparam int ROW_W = $clog2(V_TOTAL),
  localparam int ADDR_W = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              restart,
  output logic              pixel_en,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic              line_start,
  output logic              frame_start,
  output logic [ADDR_W-1:0] pixel_addr
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_count
`endif
);
  logic step, h_last, v_last, wrap;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic hs_q, hs_d, vs_q, vs_d, act_q, act_d, ls_q, ls_d, fs_q, fs_d;
  region_e h_reg, v_reg;
  vga_pixel_strobe #(.CLK_DIV(CLK_DIV)) u_strobe (
    .clk(clk),
    .n_rst(n_rst),
    .enable(enable),
    .restart(restart),
    .step(step),
    .pixel_en(pixel_en)
  );
  always_comb begin
    h_last = col_q == COL_W'(H_TOTAL - 1);
    v_last = row_q == ROW_W'(V_TOTAL - 1);
    wrap = step && h_last && v_last;
    col_d = restart || (step && h_last) ? '0 : step ? col_q + 1'b1 : col_q;
    row_d = restart || wrap ? '0 : step && h_last ? row_q + 1'b1 : row_q;
    h_reg = region(int'(col_d), H_ACTIVE, H_FP, H_SYNC);
    v_reg = region(int'(row_d), V_ACTIVE, V_FP, V_SYNC);
    act_d = h_reg == ACTIVE && v_reg == ACTIVE;
    addr_d = restart || wrap ? '0 : step && act_d ? addr_q + 1'b1 : addr_q;
    hs_d = (SYNC_POL == SYNC_ACTIVE_HIGH) ? h_reg == SYNC : h_reg != SYNC;
    vs_d = (SYNC_POL == SYNC_ACTIVE_HIGH) ? v_reg == SYNC : v_reg != SYNC;
    ls_d = restart || (step && h_last);
    fs_d = restart || wrap;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      col_q <= '0;
      row_q <= '0;
      addr_q <= '0;
      act_q <= 1'b1;
      hs_q <= !SYNC_POL;
      vs_q <= !SYNC_POL;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      addr_q <= addr_d;
      act_q <= act_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  assign col = col_q;
  assign row = row_q;
  assign pixel_addr = addr_q;
  assign active = act_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign line_start = ls_q;
  assign frame_start = fs_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_q, fc_d;
  always_comb fc_d = restart ? '0 : wrap ? fc_q + 1'b1 : fc_q;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) fc_q <= '0;
    else fc_q <= fc_d;
  assign frame_count = fc_q;
`endif
endmodule
